// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared definitions for the single-port RAM arbiter: default geometry
// (RAM16K: 14-bit word address, 16-bit data), the controller state
// encoding, and a small helper that turns a requester index into a
// one-hot pulse vector.
package ram_ctrl_pkg;

    localparam int AW_DEFAULT = 14;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Converts a requester index into its one-hot grant/done position.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin pick, purely combinational.
// Ports:
//   req       - request vector, bit i is requester i
//   ptr       - current priority pointer (preferred requester)
//   advance   - allow the pointer to move when a grant is made
//   valid     - at least one request is present
//   grant_idx - index of the winning requester
//   ptr_next  - pointer value to load after this decision
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       advance,
    output logic       valid,
    output logic       grant_idx,
    output logic       ptr_next
);

    // With both requesting the pointer decides; a lone requester always
    // wins. After a grant the loser becomes the preferred requester.
    always_comb begin
        valid     = |req;
        grant_idx = (req == 2'b11) ? ptr : req[1];
        ptr_next  = (advance && valid) ? ~grant_idx : ptr;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM between two requesters. Each access takes a
// fixed three cycles: IDLE (accept and latch command), ACCESS (drive the
// RAM, grant pulse), RESP (done pulse, read data available).
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   req, req_we          - per-requester request and write flag
//   req_addr, req_wdata  - packed per-requester address and write data
//   gnt, done            - one-cycle grant and completion pulses
//   rdata                - last captured read data
//   ram_e/ram_w/ram_r    - RAM enable, write strobe, read strobe
//   ram_addr, ram_din    - RAM address and write data
//   ram_dout             - combinational RAM read data
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            ram_e,
    output logic            ram_w,
    output logic            ram_r,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic arb_valid;
    logic arb_idx;
    logic arb_ptr_next;

    rr_arbiter2 u_rr_arbiter2 (
        .req       (req),
        .ptr       (ptr_q),
        .advance   (state_q == IDLE),
        .valid     (arb_valid),
        .grant_idx (arb_idx),
        .ptr_next  (arb_ptr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Requests are only looked at in IDLE; the winner's command is
    // latched so the requester is free to change its inputs from ACCESS on.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = ACCESS;
                    ptr_d   = arb_ptr_next;
                    owner_d = arb_idx;
                    we_d    = req_we[arb_idx];
                    addr_d  = arb_idx ? req_addr[AW +: AW] : req_addr[0 +: AW];
                    wdata_d = arb_idx ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    rdata_d = ram_dout;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state and forced low while rst is high,
    // so a write sitting in ACCESS when reset arrives never reaches the RAM.
    always_comb begin
        gnt      = 2'b00;
        done     = 2'b00;
        ram_e    = 1'b0;
        ram_w    = 1'b0;
        ram_r    = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (!rst) begin
            case (state_q)
                ACCESS: begin
                    gnt      = idx_to_onehot(owner_q);
                    ram_e    = 1'b1;
                    ram_w    = we_q;
                    ram_r    = !we_q;
                    ram_addr = addr_q;
                    ram_din  = wdata_q;
                end
                RESP: begin
                    done = idx_to_onehot(owner_q);
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata = rdata_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 14, meaning word-address width (RAM16K depth).
REQ-002 SHALL have parameter DW, default 16, meaning data word width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 SHALL have port req in 2, per-requester access request; bit i is requester i.
REQ-005 SHALL have port req_we in 2, per-requester write flag: 1 = write, 0 = read.
REQ-006 SHALL have port req_addr in 2*AW, packed addresses; requester i uses bits [i*AW +: AW].
REQ-007 SHALL have port req_wdata in 2*DW, packed write data; requester i uses bits [i*DW +: DW].
REQ-008 SHALL have port gnt out 2, one-cycle grant pulse to the accepted requester.
REQ-009 SHALL have port done out 2, one-cycle completion pulse to the owner.
REQ-010 SHALL have port rdata out DW, read result, valid when done is high for a read.
REQ-011 SHALL have port ram_e out 1, RAM enable.
REQ-012 SHALL have port ram_w out 1, RAM write strobe.
REQ-013 SHALL have port ram_r out 1, RAM read strobe.
REQ-014 SHALL have port ram_addr out AW, RAM address.
REQ-015 SHALL have port ram_din out DW, RAM write data.
REQ-016 SHALL have port ram_dout in DW, combinational RAM read data.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS, ACCESS->RESP and RESP->IDLE.
REQ-018 SHALL, in IDLE with any req bit high, select one requester at the clock edge, latch its we/addr/wdata, and go to ACCESS.
REQ-019 SHALL, in IDLE with req==0, remain in IDLE.
REQ-020 SHALL use round-robin arbitration: a 1-bit priority pointer names the preferred requester; on req==2'b11 the preferred requester wins; on a single request, that requester wins regardless of the pointer.
REQ-021 SHALL, after each grant, set the pointer to the requester that was not granted.
REQ-022 SHALL assert gnt[i] for exactly the ACCESS cycle; the requester may change its req/addr/wdata from the next cycle on.
REQ-023 SHALL, in ACCESS, drive ram_e=1, ram_addr and ram_din from the latched command, ram_w=latched we, and ram_r=!latched we.
REQ-024 SHALL commit a write at the clock edge that ends ACCESS.
REQ-025 SHALL, for a read, capture ram_dout into rdata at the clock edge that ends ACCESS.
REQ-026 SHALL, in RESP, pulse done[owner] for one cycle and keep rdata stable until the next read capture.
REQ-027 SHALL, outside ACCESS, drive ram_e, ram_w, ram_r, ram_addr and ram_din to 0.
REQ-028 SHALL, in IDLE and RESP, drive gnt to 0.
REQ-029 SHALL, outside RESP, drive done to 0.
REQ-030 SHALL NOT carry a request that is deasserted before the IDLE acceptance edge; it has no effect.
REQ-031 SHALL NOT sample req while in ACCESS or RESP; a request seen in RESP is evaluated in the following IDLE cycle.
REQ-032 SHALL give a fixed latency: acceptance edge to done equals 2 cycles; back-to-back throughput is one access per 3 cycles.
REQ-033 SHALL pass addresses through unmodified; no wrap-around or range check, since all 2^AW addresses are valid.

Reset
REQ-034 SHALL, while rst is sampled high, set the state to IDLE, the pointer to 0, and rdata to 0.
REQ-035 SHALL drive gnt, done and all ram_* outputs to 0 on reset.
REQ-036 SHALL gate ram_w with !rst combinationally, so a write in ACCESS during reset is not committed; an in-flight read is discarded and gives no done.
REQ-037 SHALL accept the first request on the first IDLE cycle after rst deasserts.

Structure
REQ-038 SHALL place the state enum (IDLE/ACCESS/RESP) and the defaults AW=14, DW=16 in shared package ram_ctrl_pkg.
REQ-039 SHALL implement the 2-way round-robin pick as sub-module rr_arbiter2 (req, ptr, advance -> grant index, pointer update).

Verification
REQ-040 SHALL verify a single write then read: requester 0 writes 0xBEEF at 0x0005, then reads 0x0005 -> gnt[0] in the ACCESS cycle, done[0] two cycles after acceptance, rdata=0xBEEF.
REQ-041 SHALL verify contention: req=2'b11 held after reset -> grant order 0,1,0,1, each done exactly 3 cycles apart.
REQ-042 SHALL verify boundary addresses: write 0x1234 at 0x3FFF and 0x5678 at 0x0000, read both -> 0x1234 and 0x5678, no aliasing.
REQ-043 SHALL verify a withdrawn request: req[1] pulsed for one cycle while the FSM is in ACCESS for requester 0 -> no gnt[1] and no done[1].
REQ-044 SHALL verify reset mid-write: rst high during ACCESS of a write of 0xAAAA to 0x0010 (prior value 0x1111) -> no done, and a later read returns 0x1111.
REQ-045 SHALL verify the idle outputs: req=0 for 10 cycles -> ram_e=ram_w=ram_r=0 and gnt=done=0 throughout.
